pinmux_cfg_matrix: RTL and testbench
====================================

// Module: pinmux_cfg_matrix
// PURPOSE
//  Register-programmable pad function matrix. Successor to the fixed-wiring pinmux:
//  every pad independently selects one of NFUNC peripheral functions.
//  Pad inputs pass through 2-flop synchronisers and an optional per-pad glitch filter.
//  Configured over the same reg bus used by glbl_cfg; sits between the peripherals and the io_* pads.
// PARAMETERS
//  NPAD   38  number of pads (1..64)
//  NFUNC  4   functions per pad (2..16); function 0 = idle GPIO input
//  FLT_W  4   glitch-filter counter width (bits)
// PORTS
//  mclk       in   1            system clock, single clock domain
//  reset_n    in   1            asynchronous active-low reset
//  reg_cs     in   1            register access request; held until reg_ack
//  reg_wr     in   1            1=write, 0=read
//  reg_addr   in   8            byte address; [1:0] ignored
//  reg_wdata  in   32           write data
//  reg_be     in   4            byte enables for writes
//  reg_rdata  out  32           read data, valid with reg_ack
//  reg_ack    out  1            one-cycle access acknowledge
//  func_out   in   NFUNC*NPAD   peripheral output, bit f*NPAD+p = function f on pad p
//  func_oeb   in   NFUNC*NPAD   peripheral output-enable-bar, same indexing
//  func_in    out  NFUNC*NPAD   synchronised/filtered pad input routed to function f
//  io_in      in   NPAD         pad inputs (asynchronous)
//  io_out     out  NPAD         pad outputs
//  io_oeb     out  NPAD         pad output-enable-bar (1 = input)
// BEHAVIOUR
//  Register map (32-bit words):
//   0x00-0x1C  FSEL[k]: nibble n selects function for pad 8k+n; only low log2(NFUNC) bits stored,
//              upper nibble bits read 0; nibbles for p>=NPAD read 0, writes ignored
//   0x20/0x24  FLT_EN lo/hi: bit p enables filter on pad p (bits >= NPAD read 0)
//   0x28       FLT_THR[FLT_W-1:0]: stability threshold, shared by all pads
//   0x30/0x34  PAD_IN lo/hi: read-only, filtered pad values; writes ignored
//   other      read 0, writes ignored, still acknowledged
//  Handshake: reg_ack=1 in the cycle after reg_cs=1 && reg_ack=0; exactly one cycle wide.
//   Held reg_cs therefore acks every 2nd cycle. Write takes effect on the ack edge, honouring reg_be.
//   reg_rdata registered with ack, 0 when reg_ack=0.
//  Output mux (combinational from FSEL regs): sel=0 -> io_out[p]=0, io_oeb[p]=1;
//   sel=f>0 -> io_out[p]=func_out[f*NPAD+p], io_oeb[p]=func_oeb[f*NPAD+p].
//   sel>=NFUNC cannot occur (bits truncated).
//  Input path: 2-flop sync per pad (s). Filtered value y: FLT_EN=0 or FLT_THR=0 -> y=s, registered,
//   so total io_in->y latency is 3 cycles. Otherwise a per-pad counter increments while s!=y and
//   clears when s==y; when it reaches FLT_THR, y<=s and counter clears.
//   A pulse shorter than FLT_THR cycles never reaches y. Counter saturates, never wraps.
//  func_in[f*NPAD+p] = y[p] if FSEL(p)==f, else 0 (function 0 also receives its pad).
//  Changing FLT_EN or FLT_THR clears all filter counters in the same cycle; y is kept.
//  Reset (async, any time incl. mid-access): FSEL=0, FLT_EN=0, FLT_THR=0, sync/y/counters=0,
//   reg_ack=0, reg_rdata=0 -> io_out=0, io_oeb=all 1, func_in=0. An access in flight is dropped.
// TESTING
//  1 Reset -> io_oeb=all 1, io_out=0, func_in=0, all registers read 0.
//  2 Write 0x00=0x0000_0021 be=F -> pad0 func1, pad1 func2; func_out[1*38+0]=1, func_oeb=0
//    -> io_out[0]=1, io_oeb[0]=0; pad2 remains input.
//  3 FSEL pad5=3, FLT_EN=0: io_in[5] 0->1 -> func_in[3*38+5]=1 exactly 3 cycles later, PAD_IN lo bit5=1.
//  4 FLT_EN bit5=1, FLT_THR=4: 3-cycle high pulse on io_in[5] -> no change;
//    6-cycle pulse -> y rises after 4 stable cycles.
//  5 Write 0x04 with be=0x2 data=0xFFFF_FFFF -> only pads 10,11 change; read 0x3C -> 0, ack given.
//  6 Held reg_cs for 4 reads -> ack pattern 0,1,0,1,0,1,0,1; reset_n low mid-access -> ack drops instantly.

Source files
------------

// File: rtl/pinmux_cfg_matrix_if.sv
// Register bus between a cfg master and pinmux_cfg_matrix.
// The request is held until reg_ack; read data is valid alongside reg_ack.
interface pinmux_cfg_matrix_if;
  logic        reg_cs;
  logic        reg_wr;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_ack;

  modport master (
    output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    input  reg_rdata, reg_ack
  );

  modport slave (
    input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    output reg_rdata, reg_ack
  );
endinterface

// File: rtl/pinmux_cfg_matrix.sv
// Register-programmable pad function matrix: per-pad function select, 2-flop
// input synchronisers and an optional per-pad glitch filter with shared threshold.
module pinmux_cfg_matrix #(
  parameter int unsigned NPAD  = 38,
  parameter int unsigned NFUNC = 4,
  parameter int unsigned FLT_W = 4
) (
  input  logic                  mclk,
  input  logic                  reset_n,
  pinmux_cfg_matrix_if.slave    reg_bus,
  input  logic [NFUNC*NPAD-1:0] func_out,
  input  logic [NFUNC*NPAD-1:0] func_oeb,
  output logic [NFUNC*NPAD-1:0] func_in,
  input  logic [NPAD-1:0]       io_in,
  output logic [NPAD-1:0]       io_out,
  output logic [NPAD-1:0]       io_oeb
);

  localparam int unsigned SEL_W  = (NFUNC > 2) ? $clog2(NFUNC) : 1;
  localparam int unsigned WORD_W = 6;

  localparam logic [WORD_W-1:0] W_FLT_EN_LO = 6'd8;
  localparam logic [WORD_W-1:0] W_FLT_EN_HI = 6'd9;
  localparam logic [WORD_W-1:0] W_FLT_THR   = 6'd10;
  localparam logic [WORD_W-1:0] W_PAD_IN_LO = 6'd12;
  localparam logic [WORD_W-1:0] W_PAD_IN_HI = 6'd13;

  logic [SEL_W-1:0]  fsel      [NPAD];
  logic [SEL_W-1:0]  fsel_nx   [NPAD];
  logic [NPAD-1:0]   flt_en;
  logic [NPAD-1:0]   flt_en_nx;
  logic [FLT_W-1:0]  flt_thr;
  logic [FLT_W-1:0]  flt_thr_nx;

  logic [NPAD-1:0]   sync_q1;
  logic [NPAD-1:0]   sync_q2;
  logic [NPAD-1:0]   y_q;
  logic [NPAD-1:0]   y_nx;
  logic [FLT_W-1:0]  cnt_q     [NPAD];
  logic [FLT_W-1:0]  cnt_nx    [NPAD];

  logic              ack_q;
  logic [31:0]       rdata_q;
  logic [31:0]       rdata_c;
  logic              acc_c;
  logic              wr_c;
  logic              cfg_clr_c;
  logic [WORD_W-1:0] word_c;
  logic [31:0]       fsel_words [8];
  logic [63:0]       en64;
  logic [63:0]       y64;
  logic              unused_ok;

  assign acc_c  = reg_bus.reg_cs && !ack_q;
  assign wr_c   = acc_c && reg_bus.reg_wr;
  assign word_c = reg_bus.reg_addr[7:2];

  assign reg_bus.reg_ack   = ack_q;
  assign reg_bus.reg_rdata = rdata_q;

  // Function 0 is idle GPIO: its peripheral outputs never reach a pad.
  assign unused_ok = ^{reg_bus.reg_addr[1:0], reg_bus.reg_wdata,
                       func_out[NPAD-1:0], func_oeb[NPAD-1:0]};

  // Readback views: FSEL packed one nibble per pad, others zero-padded to 64 pads.
  always_comb begin
    for (int unsigned k = 0; k < 8; k++) fsel_words[k] = '0;
    for (int unsigned p = 0; p < NPAD; p++) begin
      fsel_words[p/8][(p%8)*4 +: SEL_W] = fsel[p];
    end
    en64 = 64'(flt_en);
    y64  = 64'(y_q);
  end

  always_comb begin
    rdata_c = '0;
    if (word_c < 6'd8) begin
      rdata_c = fsel_words[word_c[2:0]];
    end else begin
      case (word_c)
        W_FLT_EN_LO: rdata_c = en64[31:0];
        W_FLT_EN_HI: rdata_c = en64[63:32];
        W_FLT_THR:   rdata_c = 32'(flt_thr);
        W_PAD_IN_LO: rdata_c = y64[31:0];
        W_PAD_IN_HI: rdata_c = y64[63:32];
        default:     rdata_c = '0;
      endcase
    end
  end

  // Byte-enable merge of a write into the configuration registers.
  always_comb begin
    flt_en_nx  = flt_en;
    flt_thr_nx = flt_thr;
    for (int unsigned p = 0; p < NPAD; p++) begin
      fsel_nx[p] = fsel[p];
      if (wr_c && (word_c == WORD_W'(p/8)) && reg_bus.reg_be[(p%8)/2]) begin
        fsel_nx[p] = reg_bus.reg_wdata[(p%8)*4 +: SEL_W];
      end
      if (wr_c && (word_c == ((p < 32) ? W_FLT_EN_LO : W_FLT_EN_HI))
          && reg_bus.reg_be[(p%32)/8]) begin
        flt_en_nx[p] = reg_bus.reg_wdata[p%32];
      end
    end
    for (int unsigned b = 0; b < FLT_W; b++) begin
      if (wr_c && (word_c == W_FLT_THR) && reg_bus.reg_be[b/8]) begin
        flt_thr_nx[b] = reg_bus.reg_wdata[b];
      end
    end
    cfg_clr_c = (flt_en_nx != flt_en) || (flt_thr_nx != flt_thr);
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      flt_en  <= '0;
      flt_thr <= '0;
      for (int unsigned p = 0; p < NPAD; p++) fsel[p] <= '0;
    end else begin
      ack_q   <= acc_c;
      rdata_q <= (acc_c && !reg_bus.reg_wr) ? rdata_c : 32'h0;
      flt_en  <= flt_en_nx;
      flt_thr <= flt_thr_nx;
      for (int unsigned p = 0; p < NPAD; p++) fsel[p] <= fsel_nx[p];
    end
  end

  // Glitch filter: y follows s only after s has differed for flt_thr cycles.
  always_comb begin
    logic [FLT_W-1:0] cnt_inc;
    logic             filt_on;
    cnt_inc = '0;
    filt_on = 1'b0;
    y_nx    = y_q;
    for (int unsigned p = 0; p < NPAD; p++) begin
      cnt_inc   = (cnt_q[p] == '1) ? cnt_q[p] : cnt_q[p] + FLT_W'(1);
      filt_on   = flt_en[p] && (flt_thr != '0);
      cnt_nx[p] = '0;
      if (!filt_on) begin
        y_nx[p] = sync_q2[p];
      end else if (sync_q2[p] != y_q[p]) begin
        if (cnt_inc >= flt_thr) y_nx[p] = sync_q2[p];
        else                    cnt_nx[p] = cnt_inc;
      end
      if (cfg_clr_c) cnt_nx[p] = '0;
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      y_q     <= '0;
      for (int unsigned p = 0; p < NPAD; p++) cnt_q[p] <= '0;
    end else begin
      sync_q1 <= io_in;
      sync_q2 <= sync_q1;
      y_q     <= y_nx;
      for (int unsigned p = 0; p < NPAD; p++) cnt_q[p] <= cnt_nx[p];
    end
  end

  // Pad-side mux and per-function input routing, combinational from FSEL.
  always_comb begin
    io_out  = '0;
    io_oeb  = '1;
    func_in = '0;
    for (int unsigned p = 0; p < NPAD; p++) begin
      for (int unsigned f = 1; f < NFUNC; f++) begin
        if (fsel[p] == SEL_W'(f)) begin
          io_out[p] = func_out[f*NPAD+p];
          io_oeb[p] = func_oeb[f*NPAD+p];
        end
      end
      for (int unsigned f = 0; f < NFUNC; f++) begin
        func_in[f*NPAD+p] = y_q[p] && (fsel[p] == SEL_W'(f));
      end
    end
  end

endmodule

// File: tb/tb_pinmux_cfg_matrix.sv
// Randomised bench for pinmux_cfg_matrix against a behavioural pad/register model,
// plus directed literal checks of reset, muxing, filter timing and the bus handshake.
module tb_pinmux_cfg_matrix;
  localparam int NPAD  = 38;
  localparam int NFUNC = 4;
  localparam int FLT_W = 4;
  localparam int NF    = NPAD * NFUNC;

  logic            mclk;
  logic            reset_n;
  logic [NF-1:0]   func_out;
  logic [NF-1:0]   func_oeb;
  logic [NF-1:0]   func_in;
  logic [NPAD-1:0] io_in;
  logic [NPAD-1:0] io_out;
  logic [NPAD-1:0] io_oeb;

  pinmux_cfg_matrix_if bus();

  pinmux_cfg_matrix #(.NPAD(NPAD), .NFUNC(NFUNC), .FLT_W(FLT_W)) dut (
    .mclk     (mclk),
    .reset_n  (reset_n),
    .reg_bus  (bus),
    .func_out (func_out),
    .func_oeb (func_oeb),
    .func_in  (func_in),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb)
  );

  int   checks   = 0;
  int   failures = 0;
  logic check_on = 1'b0;
  logic rand_io  = 1'b0;

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int              m_fsel [NPAD];
  int              m_run  [NPAD];
  logic [NPAD-1:0] m_en;
  logic [NPAD-1:0] m_y;
  int              m_thr;
  logic [NPAD-1:0] m_hist [2];
  logic            m_ack;
  logic [31:0]     m_rdata;

  function automatic logic [31:0] m_read(input int word);
    logic [31:0] r;
    r = '0;
    if (word < 8) begin
      for (int n = 0; n < 8; n++)
        if (8*word + n < NPAD) r = r | (32'(m_fsel[8*word+n]) << (4*n));
    end else if (word == 8 || word == 12) begin
      for (int b = 0; b < 32 && b < NPAD; b++) r[b] = (word == 8) ? m_en[b] : m_y[b];
    end else if (word == 9 || word == 13) begin
      for (int b = 32; b < NPAD; b++) r[b-32] = (word == 9) ? m_en[b] : m_y[b];
    end else if (word == 10) begin
      r = 32'(m_thr);
    end
    return r;
  endfunction

  task automatic m_write(input int word, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] t;
    if (word < 8) begin
      for (int n = 0; n < 8; n++)
        if (8*word + n < NPAD && be[n/2]) m_fsel[8*word+n] = int'((wd >> (4*n)) & 32'(NFUNC-1));
    end else if (word == 8) begin
      for (int p = 0; p < 32 && p < NPAD; p++) if (be[p/8]) m_en[p] = wd[p];
    end else if (word == 9) begin
      for (int p = 32; p < NPAD; p++) if (be[(p-32)/8]) m_en[p] = wd[p-32];
    end else if (word == 10) begin
      t = 32'(m_thr);
      for (int i = 0; i < 4; i++)
        if (be[i]) t = (t & ~(32'hFF << (8*i))) | (wd & (32'hFF << (8*i)));
      m_thr = int'(t & ((32'd1 << FLT_W) - 32'd1));
    end
  endtask

  task automatic m_step();
    logic            acc;
    int              word;
    logic [NPAD-1:0] s;
    logic [NPAD-1:0] old_en;
    int              old_thr;
    if (!reset_n) begin
      for (int p = 0; p < NPAD; p++) begin m_fsel[p] = 0; m_run[p] = 0; end
      m_en = '0; m_y = '0; m_thr = 0; m_hist[0] = '0; m_hist[1] = '0;
      m_ack = 1'b0; m_rdata = '0;
    end else begin
      acc     = bus.reg_cs && !m_ack;
      word    = int'(bus.reg_addr[7:2]);
      m_rdata = (acc && !bus.reg_wr) ? m_read(word) : 32'h0;
      m_ack   = acc;
      s       = m_hist[1];
      for (int p = 0; p < NPAD; p++) begin
        if (!m_en[p] || m_thr == 0) begin
          m_y[p] = s[p]; m_run[p] = 0;
        end else if (s[p] == m_y[p]) begin
          m_run[p] = 0;
        end else begin
          if (m_run[p] < (1 << FLT_W) - 1) m_run[p]++;
          if (m_run[p] >= m_thr) begin m_y[p] = s[p]; m_run[p] = 0; end
        end
      end
      old_en = m_en; old_thr = m_thr;
      if (acc && bus.reg_wr) m_write(word, bus.reg_wdata, bus.reg_be);
      if (m_en != old_en || m_thr != old_thr)
        for (int p = 0; p < NPAD; p++) m_run[p] = 0;
      m_hist[1] = m_hist[0];
      m_hist[0] = io_in;
    end
  endtask

  initial forever begin
    @(posedge mclk or negedge reset_n);
    m_step();
  end

  // ---------------- per-cycle compare ----------------
  logic [NPAD-1:0] e_out;
  logic [NPAD-1:0] e_oeb;
  logic [NF-1:0]   e_fin;

  initial forever begin
    @(negedge mclk);
    if (check_on && reset_n) begin
      e_out = '0; e_oeb = '1; e_fin = '0;
      for (int p = 0; p < NPAD; p++) begin
        if (m_fsel[p] != 0) begin
          e_out[p] = func_out[m_fsel[p]*NPAD + p];
          e_oeb[p] = func_oeb[m_fsel[p]*NPAD + p];
        end
        e_fin[m_fsel[p]*NPAD + p] = m_y[p];
      end
      chk("io_out",    256'(io_out),        256'(e_out));
      chk("io_oeb",    256'(io_oeb),        256'(e_oeb));
      chk("func_in",   256'(func_in),       256'(e_fin));
      chk("reg_ack",   256'(bus.reg_ack),   256'(m_ack));
      chk("reg_rdata", 256'(bus.reg_rdata), 256'(m_rdata));
    end
  end

  // ---------------- random pad/peripheral driver ----------------
  initial forever begin
    @(posedge mclk);
    #1;
    if (rand_io) begin
      for (int i = 0; i < NF; i++) begin
        func_out[i] = 1'($urandom_range(0, 1));
        func_oeb[i] = 1'($urandom_range(0, 1));
      end
      for (int p = 0; p < NPAD; p++)
        if ($urandom_range(0, 9) == 0) io_in[p] = ~io_in[p];
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic bus_op(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic ok);
    bus.reg_cs = 1'b1; bus.reg_wr = wr; bus.reg_addr = addr;
    bus.reg_wdata = wd; bus.reg_be = be;
    ok = 1'b0; rd = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.reg_ack) begin ok = 1'b1; rd = bus.reg_rdata; break; end
    end
    bus.reg_cs = 1'b0; bus.reg_wr = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL bus_timeout: no ack for addr %0h at %0t", addr, $time);
    end
  endtask

  task automatic rd_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        ok;
    bus_op(1'b0, addr, 32'h0, 4'h0, rd, ok);
    if (ok) chk(name, 256'(rd), 256'(exp));
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] rd;
    logic        ok;
    bus_op(1'b1, addr, wd, be, rd, ok);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] rd;
    logic        ok;
    int          word;
    reset_n = 1'b1;
    bus.reg_cs = 1'b0; bus.reg_wr = 1'b0; bus.reg_addr = '0;
    bus.reg_wdata = '0; bus.reg_be = '0;
    io_in = '0; func_out = '0; func_oeb = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge mclk);
    #1;
    chk("rst_io_oeb",  256'(io_oeb),      256'({NPAD{1'b1}}));
    chk("rst_io_out",  256'(io_out),      256'(0));
    chk("rst_func_in", 256'(func_in),     256'(0));
    chk("rst_ack",     256'(bus.reg_ack), 256'(0));
    reset_n  = 1'b1;
    check_on = 1'b1;
    tick();
    for (int w = 0; w < 16; w++) rd_chk("rst_reg", 8'(w*4), 32'h0);

    // pad0 -> func1, pad1 -> func2
    func_out[1*NPAD + 0] = 1'b1;
    wr_reg(8'h00, 32'h0000_0021, 4'hF);
    chk("mux_out0", 256'(io_out[0]), 256'(1));
    chk("mux_oeb0", 256'(io_oeb[0]), 256'(0));
    chk("mux_oeb2", 256'(io_oeb[2]), 256'(1));

    // pad5 -> func3, unfiltered latency of 3 cycles
    wr_reg(8'h00, 32'h0030_0021, 4'hF);
    io_in[5] = 1'b1;
    tick(); tick();
    chk("lat_cyc2", 256'(func_in[3*NPAD+5]), 256'(0));
    tick();
    chk("lat_cyc3", 256'(func_in[3*NPAD+5]), 256'(1));
    rd_chk("pad_in_lo", 8'h30, 32'h0000_0020);

    // filter on pad5, threshold 4
    io_in[5] = 1'b0;
    repeat (4) tick();
    wr_reg(8'h20, 32'h0000_0020, 4'hF);
    wr_reg(8'h28, 32'h0000_0004, 4'hF);
    rd_chk("flt_thr", 8'h28, 32'h4);
    io_in[5] = 1'b1;
    repeat (3) tick();
    io_in[5] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k % 3 == 0) chk("short_pulse", 256'(func_in[3*NPAD+5]), 256'(0));
    end
    io_in[5] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) chk("long_pulse_c5", 256'(func_in[3*NPAD+5]), 256'(0));
      if (k == 6) chk("long_pulse_c6", 256'(func_in[3*NPAD+5]), 256'(1));
    end
    io_in[5] = 1'b0;
    repeat (12) tick();

    // byte-enable on FSEL word 1 touches only pads 10/11
    wr_reg(8'h04, 32'hFFFF_FFFF, 4'h2);
    rd_chk("fsel_w1_be", 8'h04, 32'h0000_3300);
    rd_chk("fsel_w0",    8'h00, 32'h0030_0021);
    rd_chk("unmapped",   8'h3C, 32'h0);

    // held reg_cs: ack every second cycle
    tick();
    bus.reg_cs = 1'b1; bus.reg_wr = 1'b0; bus.reg_addr = 8'h00;
    for (int k = 0; k < 8; k++) begin
      chk("ack_pattern", 256'(bus.reg_ack), 256'(k % 2));
      tick();
    end
    tick();
    chk("ack_before_rst", 256'(bus.reg_ack), 256'(1));
    #3 reset_n = 1'b0;
    #1;
    chk("ack_async_rst",   256'(bus.reg_ack),   256'(0));
    chk("rdata_async_rst", 256'(bus.reg_rdata), 256'(0));
    chk("oeb_async_rst",   256'(io_oeb),        256'({NPAD{1'b1}}));
    bus.reg_cs = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    rd_chk("fsel_after_rst", 8'h00, 32'h0);

    // randomised traffic
    rand_io = 1'b1;
    for (int i = 0; i < 400; i++) begin
      word = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 63));
      bus_op(1'($urandom_range(0, 1)), {6'(word), 2'($urandom_range(0, 3))},
             $urandom, 4'($urandom_range(0, 15)), rd, ok);
      repeat ($urandom_range(0, 3)) tick();
      if (i % 50 == 49) begin
        rand_io = 1'b0;
        repeat (20) tick();
        rand_io = 1'b1;
      end
    end
    rand_io = 1'b0;
    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
